// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: walks a position counter through FRAME_LEN cycles and
// produces registered start / shift / str / frame_done timing pulses.
// Runs continuous frames (mode=0) or one frame per trig (mode=1), can be
// paused with en and restarted with sync_clr; also counts completed frames.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped, cnt held at 0, pulses low, waiting for en (and trig)
// RUN   | advancing cnt one position per clock, decoding pulses
// PAUSE | en dropped mid-frame, cnt frozen, pulses low until en returns
module frame_seq_ctrl #(
    parameter int CNT_W     = 4,
    parameter int FRAME_LEN = 16,
    parameter int START_POS = 0,
    parameter int STR_POS   = 15,
    parameter int FCNT_W    = 8
) (
    input  logic              clk_25k,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              trig,
    input  logic              sync_clr,
    output logic              start,
    output logic              str,
    output logic              shift,
    output logic              frame_done,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] START_C = CNT_W'(START_POS);
    localparam logic [CNT_W-1:0] STR_C   = CNT_W'(STR_POS);

    state_t state;

    // Sequencer state, position counter, frame counter and registered pulses.
    // Resuming from PAUSE with en high processes the held position on that
    // same edge, so a pause of N cycles delays the frame by exactly N cycles.
    always_ff @(posedge clk_25k or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_cnt  <= '0;
            start      <= 1'b0;
            str        <= 1'b0;
            shift      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (sync_clr) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_cnt  <= '0;
            start      <= 1'b0;
            str        <= 1'b0;
            shift      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    start      <= 1'b0;
                    str        <= 1'b0;
                    shift      <= 1'b0;
                    frame_done <= 1'b0;
                    if (en && (!mode || trig)) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RUN, PAUSE: begin
                    if (!en) begin
                        state      <= PAUSE;
                        busy       <= 1'b1;
                        start      <= 1'b0;
                        str        <= 1'b0;
                        shift      <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        start      <= (cnt == START_C);
                        str        <= (cnt == STR_C);
                        shift      <= (cnt > START_C) && (cnt < STR_C);
                        frame_done <= (cnt == LAST_C);
                        if (cnt == LAST_C) begin
                            cnt       <= '0;
                            frame_cnt <= frame_cnt + FCNT_W'(1);
                            // mode only matters at the frame boundary
                            if (mode) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    start      <= 1'b0;
                    str        <= 1'b0;
                    shift      <= 1'b0;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Bench for frame_seq_ctrl: default instance plus a short-frame instance
// (FRAME_LEN=5) sharing one stimulus, checked every edge against a
// position-level model and pinned with hand-computed literals.
module tb_frame_seq_ctrl;

    logic clk_25k = 1'b0;
    logic rst = 1'b0, en = 1'b0, mode = 1'b0, trig = 1'b0, sync_clr = 1'b0;

    logic       start0, str0, shift0, fd0, busy0;
    logic [3:0] cnt0;
    logic [7:0] fc0;
    logic       start1, str1, shift1, fd1, busy1;
    logic [2:0] cnt1;
    logic [1:0] fc1;

    int checks = 0;
    int errors = 0;

    always #10 clk_25k = ~clk_25k;

    frame_seq_ctrl #(.CNT_W(4), .FRAME_LEN(16), .START_POS(0), .STR_POS(15), .FCNT_W(8)) u_dut0 (
        .clk_25k(clk_25k), .rst(rst), .en(en), .mode(mode), .trig(trig), .sync_clr(sync_clr),
        .start(start0), .str(str0), .shift(shift0), .frame_done(fd0), .busy(busy0),
        .cnt(cnt0), .frame_cnt(fc0));

    frame_seq_ctrl #(.CNT_W(3), .FRAME_LEN(5), .START_POS(1), .STR_POS(3), .FCNT_W(2)) u_dut1 (
        .clk_25k(clk_25k), .rst(rst), .en(en), .mode(mode), .trig(trig), .sync_clr(sync_clr),
        .start(start1), .str(str1), .shift(shift1), .frame_done(fd1), .busy(busy1),
        .cnt(cnt1), .frame_cnt(fc1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which position was processed on the last edge, where the frame
    // stands now, and how many frames have finished.
    int FL[2] = '{16, 5};
    int SP[2] = '{0, 1};
    int RP[2] = '{15, 3};
    int FM[2] = '{256, 4};
    int m_act[2]    = '{0, 0};   // 0 stopped, 1 running, 2 paused
    int m_pos[2]    = '{0, 0};
    int m_frames[2] = '{0, 0};
    int m_last[2]   = '{-1, -1};

    task automatic mstep(input int i);
        if (!rst || sync_clr) begin
            m_act[i] = 0; m_pos[i] = 0; m_frames[i] = 0; m_last[i] = -1;
        end else if (m_act[i] == 0) begin
            m_last[i] = -1;
            if (en && (!mode || trig)) m_act[i] = 1;
        end else if (!en) begin
            m_act[i] = 2; m_last[i] = -1;
        end else begin
            m_last[i] = m_pos[i];
            m_pos[i]  = (m_pos[i] + 1) % FL[i];
            if (m_last[i] == FL[i] - 1) begin
                m_frames[i] = (m_frames[i] + 1) % FM[i];
                m_act[i]    = mode ? 0 : 1;
            end else begin
                m_act[i] = 1;
            end
        end
    endtask

    task automatic mcmp(input int i, input int s, input int st, input int sh, input int fd,
                        input int b, input int c, input int f);
        int l;
        l = m_last[i];
        chk($sformatf("u%0d start", i), s, int'(l == SP[i]));
        chk($sformatf("u%0d str", i), st, int'(l == RP[i]));
        chk($sformatf("u%0d shift", i), sh, int'(l > SP[i] && l < RP[i]));
        chk($sformatf("u%0d frame_done", i), fd, int'(l == FL[i] - 1));
        chk($sformatf("u%0d busy", i), b, int'(m_act[i] != 0));
        chk($sformatf("u%0d cnt", i), c, m_pos[i]);
        chk($sformatf("u%0d frame_cnt", i), f, m_frames[i]);
        chk($sformatf("u%0d start_and_str", i), s & st, 0);
    endtask

    // Advance the model on each edge, then compare both instances 1 ns later.
    always @(posedge clk_25k) begin
        mstep(0);
        mstep(1);
        #1;
        mcmp(0, int'(start0), int'(str0), int'(shift0), int'(fd0), int'(busy0), int'(cnt0), int'(fc0));
        mcmp(1, int'(start1), int'(str1), int'(shift1), int'(fd1), int'(busy1), int'(cnt1), int'(fc1));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_25k);
    endtask

    initial begin
        step(2);
        // continuous frames from reset release
        rst = 1'b1; en = 1'b1; mode = 1'b0;
        step(1);
        chk("e1 busy", int'(busy0), 1); chk("e1 start", int'(start0), 0); chk("e1 cnt", int'(cnt0), 0);
        step(1);
        chk("e2 start", int'(start0), 1); chk("e2 cnt", int'(cnt0), 1);
        step(1);
        chk("e3 shift", int'(shift0), 1); chk("e3 start", int'(start0), 0);
        step(13);
        chk("e16 shift", int'(shift0), 1); chk("e16 str", int'(str0), 0); chk("e16 cnt", int'(cnt0), 15);
        step(1);
        chk("e17 str", int'(str0), 1); chk("e17 frame_done", int'(fd0), 1); chk("e17 shift", int'(shift0), 0);
        chk("e17 frame_cnt", int'(fc0), 1); chk("e17 cnt", int'(cnt0), 0);
        chk("e17 small start", int'(start1), 0); chk("e17 small cnt", int'(cnt1), 1);
        chk("e17 small frame_cnt", int'(fc1), 3);
        step(1);
        chk("e18 start", int'(start0), 1); chk("e18 cnt", int'(cnt0), 1);
        chk("e18 small start", int'(start1), 1);
        step(3);
        chk("e21 small frame_done", int'(fd1), 1); chk("e21 small frame_cnt wrap", int'(fc1), 0);
        chk("e21 small cnt", int'(cnt1), 0); chk("e21 cnt", int'(cnt0), 4);
        step(5);
        chk("e26 cnt", int'(cnt0), 9);
        // sync_clr beats en at cnt=9
        sync_clr = 1'b1;
        step(1);
        chk("clr cnt", int'(cnt0), 0); chk("clr frame_cnt", int'(fc0), 0);
        chk("clr busy", int'(busy0), 0); chk("clr str", int'(str0), 0);
        sync_clr = 1'b0;
        step(1);
        chk("restart busy", int'(busy0), 1); chk("restart cnt", int'(cnt0), 0);
        // pause at cnt=7 for three cycles
        step(7);
        chk("pre-pause cnt", int'(cnt0), 7); chk("pre-pause shift", int'(shift0), 1);
        en = 1'b0;
        step(3);
        chk("pause cnt", int'(cnt0), 7); chk("pause shift", int'(shift0), 0); chk("pause busy", int'(busy0), 1);
        en = 1'b1;
        step(8);
        chk("resume cnt", int'(cnt0), 15); chk("resume str early", int'(str0), 0);
        step(1);
        chk("resume str", int'(str0), 1); chk("resume frame_cnt", int'(fc0), 1);
        // single-shot frames
        sync_clr = 1'b1; mode = 1'b1;
        step(1);
        sync_clr = 1'b0;
        step(3);
        chk("ss idle busy", int'(busy0), 0); chk("ss idle cnt", int'(cnt0), 0);
        trig = 1'b1;
        step(1);
        chk("ss launch busy", int'(busy0), 1);
        trig = 1'b0;
        step(1);
        chk("ss start", int'(start0), 1); chk("ss frame_cnt0", int'(fc0), 0);
        step(4);
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        chk("ss mid trig busy", int'(busy0), 1);
        step(9);
        chk("ss cnt15", int'(cnt0), 15); chk("ss str early", int'(str0), 0); chk("ss busy15", int'(busy0), 1);
        step(1);
        chk("ss str", int'(str0), 1); chk("ss frame_done", int'(fd0), 1);
        chk("ss busy drop", int'(busy0), 0); chk("ss frame_cnt", int'(fc0), 1);
        step(1);
        chk("ss after busy", int'(busy0), 0); chk("ss after start", int'(start0), 0);
        step(20);
        chk("ss no relaunch busy", int'(busy0), 0); chk("ss no relaunch frame_cnt", int'(fc0), 1);
        // async reset mid-frame
        mode = 1'b0;
        step(6);
        #2 rst = 1'b0;
        #1;
        chk("rst busy", int'(busy0), 0); chk("rst cnt", int'(cnt0), 0); chk("rst frame_cnt", int'(fc0), 0);
        chk("rst shift", int'(shift0), 0); chk("rst start", int'(start0), 0);
        chk("rst str", int'(str0), 0); chk("rst frame_done", int'(fd0), 0); chk("rst small busy", int'(busy1), 0);
        step(1);
        rst = 1'b1;
        step(1);
        chk("post-rst busy", int'(busy0), 1);
        step(1);
        chk("post-rst start", int'(start0), 1);
        step(15);
        chk("post-rst str", int'(str0), 1); chk("post-rst frame_done", int'(fd0), 1);
        chk("post-rst frame_cnt", int'(fc0), 1);
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
